// File: rtl/cla_byte_seq_if.sv
// Operand/result bus of cla_byte_seq. The master drives operands and out_ready;
// the slave (the sequencer) drives in_ready and the result. sub exists only with CLA_SEQ_SUB_EN.
interface cla_byte_seq_if #(
  parameter int NBYTES = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   a;
  logic [8*NBYTES-1:0]   b;
  logic                  cin;
`ifdef CLA_SEQ_SUB_EN
  logic                  sub;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   sum;
  logic                  cout;
  logic                  ovf;

`ifdef CLA_SEQ_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`endif
endinterface

// File: rtl/cla_byte_seq.sv
// Byte-serial wide adder: one cla_8bit reused LSB-first over NBYTES cycles.
// Optional subtract mode is compiled in with CLA_SEQ_SUB_EN.

module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_start,
  output logic [7:0] sum,
  output logic       carry_out
);
  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       term;
  logic       pp;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of products of generate/propagate terms, not a ripple chain.
  always_comb begin
    c    = '0;
    term = 1'b0;
    pp   = 1'b0;
    c[0] = carry_start;
    for (int i = 0; i < 8; i++) begin
      term = g[i];
      pp   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (pp & g[j]);
        pp   = pp & p[j];
      end
      c[i+1] = term | (pp & carry_start);
    end
  end

  assign sum       = p ^ c[7:0];
  assign carry_out = c[8];
endmodule

module cla_byte_seq #(
  parameter int NBYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  cla_byte_seq_if.slave     bus,
  output logic [1:0]        dbg_state
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready is high only in IDLE, out_valid only in DONE, and neither depends on the peer's signal.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_lat;
  logic [W-1:0]    b_lat;
  logic [W-1:0]    sum_r;
  logic            carry;
  logic            cout_r;
  logic            ovf_r;
  logic [W-1:0]    b_eff;
  logic            c_init;
  logic [7:0]      byte_a;
  logic [7:0]      byte_b;
  logic [7:0]      byte_s;
  logic            byte_c;
  logic            last;

`ifdef CLA_SEQ_SUB_EN
  assign b_eff  = bus.sub ? ~bus.b : bus.b;
  assign c_init = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_eff  = bus.b;
  assign c_init = bus.cin;
`endif

  assign byte_a = a_lat[{idx, 3'b000} +: 8];
  assign byte_b = b_lat[{idx, 3'b000} +: 8];
  assign last   = (idx == IW'(NBYTES - 1));

  cla_8bit u_cla (
    .a           (byte_a),
    .b           (byte_b),
    .carry_start (carry),
    .sum         (byte_s),
    .carry_out   (byte_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nx = RUN;
      RUN:     if (last)          state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // in_ready is masked by rst so nothing looks acceptable during the reset cycle.
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_lat  <= '0;
      b_lat  <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_lat <= bus.a;
            b_lat <= b_eff;
            carry <= c_init;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_r[{idx, 3'b000} +: 8] <= byte_s;
          carry <= byte_c;
          idx   <= idx + 1'b1;
          if (last) begin
            cout_r <= byte_c;
            ovf_r  <= (a_lat[W-1] == b_lat[W-1]) && (byte_s[7] != a_lat[W-1]);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_byte_seq.sv
// Directed bench for cla_byte_seq: a wide-arithmetic reference model feeds an expected
// queue that is checked every cycle out_valid is high, plus literal per-test expectations.
module tb_cla_byte_seq;
  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;
`ifdef CLA_SEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         checks;
  int         failures;
  logic [W+1:0] exp_q[$];

  cla_byte_seq_if #(.NBYTES(NBYTES)) bus ();

  cla_byte_seq #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard compare process ----------------
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%h expected=none", bus.sum);
      end else begin
        chk("model_result", 64'({bus.sum, bus.cout, bus.ovf}), 64'(exp_q[0]));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                      input logic tcin, input logic tsub);
    int n;
    logic use_sub;
    logic [W-1:0] be;
    logic c;
    logic [W:0] full;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=0 expected=1");
    end
    use_sub = tsub && SUB_EN;
    bus.a = ta;
    bus.b = tbv;
    bus.cin = tcin;
`ifdef CLA_SEQ_SUB_EN
    bus.sub = tsub;
`endif
    bus.in_valid = 1'b1;
    be   = use_sub ? ~tbv : tbv;
    c    = use_sub ? 1'b1 : tcin;
    full = {1'b0, ta} + {1'b0, be} + (W+1)'(c);
    exp_q.push_back({full[W-1:0], full[W], (ta[W-1] == be[W-1]) && (full[W-1] != ta[W-1])});
    @(posedge clk); #1;
    // Scramble the inputs after acceptance; the latched operands must win.
    bus.in_valid = 1'b0;
    bus.a   = ~ta;
    bus.b   = ~tbv;
    bus.cin = ~tcin;
`ifdef CLA_SEQ_SUB_EN
    bus.sub = ~tsub;
`endif
  endtask

  task automatic wait_out(output int k);
    k = 0;
    while (bus.out_valid !== 1'b1 && k < 50) begin
      @(posedge clk); #1; k++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic tcin, input logic tsub,
                        input logic [W-1:0] esum, input logic ecout, input logic eovf);
    int k;
    bus.out_ready = 1'b1;
    send(ta, tbv, tcin, tsub);
    wait_out(k);
    chk({name, "_latency"}, 64'(k), 64'(NBYTES));
    chk({name, "_literal"}, 64'({bus.sum, bus.cout, bus.ovf}), 64'({esum, ecout, eovf}));
    @(posedge clk); #1;
    chk({name, "_consumed"}, 64'(bus.out_valid), 64'(0));
    chk({name, "_retained"}, 64'({bus.sum, bus.cout, bus.ovf}), 64'({esum, ecout, eovf}));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a   = '0;
    bus.b   = '0;
    bus.cin = 1'b0;
`ifdef CLA_SEQ_SUB_EN
    bus.sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready_low", 64'(bus.in_ready), 64'(0));
    chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset_outputs", 64'({bus.sum, bus.cout, bus.ovf}), 64'(0));
    rst = 1'b0;
    #1;
    chk("reset_in_ready_high", 64'(bus.in_ready), 64'(1));

    run_op("basic_add",  32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run_op("ripple",     32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("neg_ovf",    32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    run_op("mixed",      32'h89AB_CDEF, 32'h7654_3210, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

    // Backpressure: hold DONE while new operands are offered and must be ignored.
    bus.out_ready = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_out(k);
    chk("bp_latency", 64'(k), 64'(NBYTES));
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
      chk("bp_hold", 64'({bus.out_valid, bus.sum, bus.cout, bus.ovf}),
          64'({1'b1, 32'h2345_6789, 1'b0, 1'b0}));
      bus.in_valid = (i % 2 == 0);
      bus.a = 32'($urandom);
      bus.b = 32'($urandom);
      @(posedge clk); #1;
    end
    // Consume with in_valid also high: the new operand set must not be taken.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < NBYTES + 3; i++) begin
      chk("bp_no_extra_valid", 64'(bus.out_valid), 64'(0));
      @(posedge clk); #1;
    end
    chk("bp_queue_empty", 64'(exp_q.size()), 64'(0));

    // Reset abort in RUN with two bytes done.
    send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    chk("abort_out_valid", 64'(bus.out_valid), 64'(0));
    chk("abort_outputs", 64'({bus.sum, bus.cout, bus.ovf}), 64'(0));
    chk("abort_in_ready_rst", 64'(bus.in_ready), 64'(0));
    rst = 1'b0;
    #1;
    chk("abort_in_ready", 64'(bus.in_ready), 64'(1));
    for (int i = 0; i < NBYTES + 2; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 64'(bus.out_valid), 64'(0));
    end
    run_op("after_abort", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

`ifdef CLA_SEQ_SUB_EN
    run_op("sub_5_7",   32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_7_5",   32'd7, 32'd5, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    run_op("sub_ovf",   32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_op("sub0_add",  32'd10, 32'd20, 1'b1, 1'b0, 32'd31, 1'b0, 1'b0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cla_byte_seq.md
# cla_byte_seq

Byte-serial wide adder sequencer that time-multiplexes a single `cla_8bit` instance to add two NBYTES-wide operands, one byte per cycle, least-significant byte first. The inter-byte carry is held in a register. Results are delivered behind a valid/ready handshake. It sits between an operand producer and a result consumer wherever a wide add is needed, but area rules out NBYTES parallel adders.

## Interface
- `NBYTES`, default 4: operand width in bytes; legal range 2..16.
- `clk` input, 1 bit: the only clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: operand set presented.
- `in_ready` output, 1 bit: block can accept operands.
- `a` input, 8*NBYTES bits: operand A.
- `b` input, 8*NBYTES bits: operand B.
- `cin` input, 1 bit: carry into the least-significant byte.
- `sub` input, 1 bit: subtract request. Present only with `CLA_SEQ_SUB_EN`.
- `out_valid` output, 1 bit: result available.
- `out_ready` input, 1 bit: consumer takes the result.
- `sum` output, 8*NBYTES bits: result.
- `cout` output, 1 bit: carry out of the MSB.
- `ovf` output, 1 bit: two's-complement signed overflow.

## Operation
- Contains exactly one `cla_8bit` instance. Its ports are driven as follows:
  - `a` = selected byte of latched A.
  - `b` = selected byte of latched B_eff.
  - `carry_start` = carry register.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, latch A, B_eff and initial carry, clear byte index `idx`, then go to RUN.
- RUN, one cycle per byte:
  - Write `sum[8*idx +: 8]` from the adder output.
  - Carry register <= `carry_out`.
  - `idx` <= `idx`+1.
  - When `idx`==NBYTES-1: register `cout` and `ovf`, then go to DONE.
- DONE:
  - `out_valid`=1.
  - On `out_ready`, go to IDLE.
- `ovf` = (A[MSB]==B_eff[MSB]) && (`sum`[MSB]!=A[MSB]).
- All arithmetic is modulo 2^(8*NBYTES). No saturation.
- Operands are latched at acceptance. Changes on `a`, `b`, `cin` or `sub` after acceptance have no effect.
- `in_valid` is ignored outside IDLE.
- `sum`, `cout` and `ovf` are registered. They stay stable throughout DONE and keep their last value after returning to IDLE until the next RUN overwrites them.

## Timing
- Reset values:
  - State = IDLE.
  - `in_ready`=1 in the cycle after reset deasserts (0 while `rst` is high).
  - `out_valid`=0.
  - `sum`=0, `cout`=0, `ovf`=0.
  - `idx`=0, carry register = 0.
- Latency: the accept edge is T0. `out_valid` rises after edge T0+NBYTES, so it is observed NBYTES cycles after acceptance.
- Throughput: `in_ready` is high only in IDLE. Minimum initiation interval is NBYTES+2 cycles (accept, NBYTES RUN cycles, one DONE cycle with `out_ready`=1).
- Backpressure: DONE holds indefinitely while `out_ready`=0. The outputs do not change.
- `rst` mid-operation (RUN or DONE) aborts the operation on that edge:
  - The result is discarded.
  - All outputs return to their reset values.
  - No partial `out_valid` is produced.
- Simultaneous `in_valid` and `out_ready` in DONE: the result is consumed. The new operands are not accepted in that cycle.

## Configuration
- `CLA_SEQ_SUB_EN` defined:
  - The `sub` port exists.
  - `sub`=1 sets B_eff=~`b` and initial carry=1; `cin` is ignored.
  - In subtract mode, `cout`=1 means no borrow.
  - `sub`=0 behaves as add.
- `CLA_SEQ_SUB_EN` undefined:
  - No `sub` port.
  - B_eff=`b` and initial carry=`cin`.

## Test plan
- Basic add: NBYTES=4, A=0x000000FF, B=0x00000001, `cin`=0 -> `sum`=0x00000100, `cout`=0, `ovf`=0. `out_valid` rises exactly 4 cycles after acceptance.
- Full carry ripple: A=0xFFFFFFFF, B=0x00000000, `cin`=1 -> `sum`=0x00000000, `cout`=1, `ovf`=0.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001 -> `sum`=0x80000000, `ovf`=1, `cout`=0.
- Backpressure and ignored input: hold `out_ready`=0 for 5 cycles in DONE while pulsing `in_valid` with new operands:
  - `sum`, `cout`, `ovf` and `out_valid` stay stable.
  - `in_ready` stays 0.
  - The new operands are never processed.
- Reset abort: assert `rst` during RUN at `idx`=2 -> on the next cycle `out_valid`=0, `sum`=0, `in_ready`=1 after `rst` drops, and a following add of 3+4 returns 7.
- With `CLA_SEQ_SUB_EN`:
  - `sub`=1, A=5, B=7 -> `sum`=0xFFFFFFFE, `cout`=0.
  - `sub`=1, A=7, B=5 -> `sum`=0x00000002, `cout`=1.
  - `sub`=1, A=0x80000000, B=1 -> `ovf`=1.
